uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver that assembles BYTES_PER_WORD serial 8N1 bytes into one word and buffers completed words in a FIFO_DEPTH-entry FIFO. Output uses a standard valid/ready handshake toward the core's I/O unit. It adds glitch filtering, false-start rejection, framing, overrun and optional parity detection, and non-lossy buffering.

## Interface
- CLK_PER_HALF_BIT, 5208, clk cycles per half bit period; must be >= 2
- BYTES_PER_WORD, 4, bytes per output word; 1..8
- FIFO_DEPTH, 4, word entries; power of two, >= 2
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- rxd  in  1  asynchronous serial line, idle high
- rdata  out  8*BYTES_PER_WORD  FIFO head word (first-word-fallthrough)
- rdata_valid  out  1  FIFO non-empty
- rdata_ready  in  1  consumer accepts rdata this cycle
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words held
- err_clear  in  1  clears all sticky error flags
- frame_err  out  1  sticky: stop bit sampled low
- overrun_err  out  1  sticky: word completed while FIFO full
- parity_err  out  1  sticky: parity mismatch (UART_RX_PARITY_EN only)

## Operation
- Input path: rxd through 2-flop synchroniser, then 3-sample shift register; filtered bit rx_f = majority of the 3 samples.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP. A bit counter (0..7), a byte counter (0..BYTES_PER_WORD-1) and a cycle counter sized for 2*CLK_PER_HALF_BIT.
- IDLE: armed only after rx_f==1 seen; on rx_f==0 -> START, cycle counter cleared.
- START: after CLK_PER_HALF_BIT-1 cycles sample rx_f; 1 -> false start, back to IDLE (no error); 0 -> DATA.
- DATA: sample every 2*CLK_PER_HALF_BIT cycles (mid-bit), 8 bits LSB-first; after bit 7 -> PARITY or STOP.
- STOP: sample at mid-bit. rx_f==0 -> frame_err set, byte and partial word discarded, byte counter zeroed. rx_f==1 -> byte stored at rdata bits [8*k+7:8*k], k = byte counter (little-endian). On k==BYTES_PER_WORD-1 word pushed, byte counter zeroed. Always -> IDLE (re-arm needs line high, so a break does not retrigger).
- FIFO: push when full -> word dropped, overrun_err set, contents unchanged. Pop on rdata_valid && rdata_ready. Push and pop same cycle: both take effect, including when full (pop frees slot first); count unchanged.
- Pointers wrap modulo FIFO_DEPTH; fifo_count is exact 0..FIFO_DEPTH.
- Error flags: set has priority over err_clear in the same cycle.
- Reset: FSM to IDLE (disarmed), counters 0, FIFO empty, all flags 0; received partial word lost. Reset mid-frame: remaining bits of that frame are ignored until line seen high.

## Timing
- Reset values: rdata 0, rdata_valid 0, fifo_count 0, frame_err 0, overrun_err 0, parity_err 0.
- rxd to rx_f: 3 cycles (2 sync + majority register).
- rdata_valid rises the cycle after the STOP mid-bit sample of the last byte; rdata valid same cycle.
- rdata/rdata_valid change only on push/pop; rdata stable while valid && !ready.
- Pop visible next cycle: rdata updates to next entry or rdata_valid falls.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state between DATA and STOP samples one even-parity bit; mismatch sets parity_err and discards byte and partial word (byte counter zeroed); FSM still proceeds to STOP.
- Undefined: no parity bit, 8N1 framing; parity_err port present, tied to 0.

## Test plan
- CLK_PER_HALF_BIT=4, BYTES_PER_WORD=4: send 0x78,0x56,0x34,0x12 -> rdata=0x12345678, rdata_valid=1, fifo_count=1; ready=1 one cycle -> rdata_valid=0, count=0.
- rxd low pulse 2 cycles, then high -> no state change past START, no word, no error.
- Byte 0xAA with stop bit 0 -> frame_err=1, then 4 clean bytes 0x01..0x04 -> rdata=0x04030201; err_clear -> frame_err=0.
- FIFO_DEPTH=4, ready=0, send 5 words -> fifo_count=4, overrun_err=1, pops return words 1..4 in order.
- FIFO full, last stop bit lands with ready=1 -> pop and push same cycle, count stays 4, no overrun.
- UART_RX_PARITY_EN, byte 0x07 with parity bit 0 -> parity_err=1, byte dropped; with parity 1 -> accepted.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: filtered 8N1 UART receiver packing BYTES_PER_WORD bytes per word into a FWFT FIFO.
// Optional even-parity framing when UART_RX_PARITY_EN is defined.
`default_nettype none

module uart_rx_fifo #(
    parameter int CLK_PER_HALF_BIT = 5208,
    parameter int BYTES_PER_WORD   = 4,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                rxd,
    output logic [8*BYTES_PER_WORD-1:0]         rdata,
    output logic                                rdata_valid,
    input  logic                                rdata_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
    input  logic                                err_clear,
    output logic                                frame_err,
    output logic                                overrun_err,
    output logic                                parity_err
);

    localparam int WW    = 8 * BYTES_PER_WORD;
    localparam int CNT_W = $clog2(2 * CLK_PER_HALF_BIT);
    localparam int BC_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(BYTES_PER_WORD - 1);
    localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    // Synchroniser and majority filter reset low so the line must be seen high before arming
    logic       sync1, sync2, rx_f;
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 2'b00;
            rx_f  <= 1'b0;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            hist  <= {hist[0], sync2};
            rx_f  <= (hist[1] & hist[0]) | (hist[1] & sync2) | (hist[0] & sync2);
        end
    end

    logic [2:0]       state, next_state;
    logic             armed, tick;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [BC_W-1:0]  byte_cnt;
    logic [7:0]       shreg;
    logic [WW-1:0]    word, push_word;
    logic             shift_en, store, push, frame_set, par_set, par_drop;

    assign tick = (state == S_START) ? (cnt == HALF_LAST) : (cnt == FULL_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (armed && !rx_f) next_state = S_START;
            S_START:  if (tick) next_state = rx_f ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:   if (tick && bit_cnt == 3'd7) next_state = S_PARITY;
            S_PARITY: if (tick) next_state = S_STOP;
`else
            S_DATA:   if (tick && bit_cnt == 3'd7) next_state = S_STOP;
`endif
            S_STOP:   if (tick) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        shift_en  = 1'b0;
        store     = 1'b0;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state)
            S_DATA: shift_en = tick;
            S_STOP: if (tick) begin
                frame_set = !rx_f;
                store     = rx_f && !par_drop;
                push      = rx_f && !par_drop && (byte_cnt == LAST_BYTE);
            end
            default: ;
        endcase
    end

    always_comb begin
        push_word = word;
        push_word[8*byte_cnt +: 8] = shreg;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            armed    <= 1'b0;
            cnt      <= '0;
            bit_cnt  <= 3'd0;
            byte_cnt <= '0;
            shreg    <= 8'd0;
            word     <= '0;
        end else begin
            // Arming needs a high line while idle, so a break or a mid-frame reset cannot retrigger
            armed <= (state == S_IDLE) && (armed || rx_f);
            cnt   <= (state == S_IDLE || tick) ? '0 : cnt + CNT_W'(1);
            if (state != S_DATA) bit_cnt <= 3'd0;
            else if (tick)       bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shreg <= {rx_f, shreg[7:1]};
            if (frame_set || par_set) byte_cnt <= '0;
            else if (store)           byte_cnt <= push ? '0 : byte_cnt + BC_W'(1);
            if (store) word <= push_word;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign par_set = (state == S_PARITY) && tick && (^{shreg, rx_f});

    always_ff @(posedge clk) begin
        if (!rstn) begin
            par_drop   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == S_IDLE) par_drop <= 1'b0;
            else if (par_set)    par_drop <= 1'b1;
            parity_err <= par_set ? 1'b1 : (err_clear ? 1'b0 : parity_err);
        end
    end
`else
    assign par_set    = 1'b0;
    assign par_drop   = 1'b0;
    assign parity_err = 1'b0;
`endif

    logic [WW-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [CW-1:0]    count;
    logic             pop, full, wr;

    assign pop  = (count != '0) && rdata_ready;
    assign full = (count == DEPTH_C);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign wr   = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (wr)  wptr <= wptr + PTR_W'(1);
            if (pop) rptr <= rptr + PTR_W'(1);
            case ({wr, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            frame_err   <= frame_set ? 1'b1 : (err_clear ? 1'b0 : frame_err);
            overrun_err <= (push && full && !pop) ? 1'b1 : (err_clear ? 1'b0 : overrun_err);
        end
    end

    assign rdata_valid = (count != '0);
    assign rdata       = rdata_valid ? mem[rptr] : '0;
    assign fifo_count  = count;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scoreboard bench for uart_rx_fifo (CLK_PER_HALF_BIT=4, 4 bytes/word, depth 4).
`default_nettype none

module tb_uart_rx_fifo;
    localparam int H     = 4;
    localparam int BPW   = 4;
    localparam int DEPTH = 4;
    localparam int BIT   = 2 * H;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rxd = 1'b1;
    logic        rdata_ready = 1'b0;
    logic        err_clear = 1'b0;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [2:0]  fifo_count;
    logic        frame_err, overrun_err, parity_err;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat = -1;
    logic [31:0] sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_fifo #(
        .CLK_PER_HALF_BIT(H),
        .BYTES_PER_WORD  (BPW),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rxd        (rxd),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .rdata_ready(rdata_ready),
        .fifo_count (fifo_count),
        .err_clear  (err_clear),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .parity_err (parity_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^b);
`endif
        send_bit(stop);
        rxd = 1'b1;
        repeat (12) @(negedge clk);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_bad_parity(input logic [7:0] b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b);
        send_bit(1'b1);
        rxd = 1'b1;
        repeat (12) @(negedge clk);
    endtask
`endif

    task automatic send_word(input logic [31:0] w, input logic expect_stored);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
        if (expect_stored) sb.push_back(w);
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] exp;
        check({tag, "_valid"}, rdata_valid, 1);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        check({tag, "_data"}, rdata, exp);
        rdata_ready = 1'b1;
        @(negedge clk);
        rdata_ready = 1'b0;
    endtask

    task automatic clear_errors();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    initial begin
        int t0;
        int lat_use;
        logic [31:0] w5;
        logic [31:0] head;

        repeat (4) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_rdata", rdata, 0);
        check("rst_valid", rdata_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun_err", overrun_err, 0);
        check("rst_parity_err", parity_err, 0);
        repeat (10) @(negedge clk);

        // Basic word, little-endian assembly
        send_word(32'h1234_5678, 1'b1);
        check("w1_valid", rdata_valid, 1);
        check("w1_count", fifo_count, 1);
        pop_check("w1_pop");
        check("w1_after_pop_valid", rdata_valid, 0);
        check("w1_after_pop_count", fifo_count, 0);

        // Two-cycle glitch is a false start
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_count", fifo_count, 0);
        check("glitch_valid", rdata_valid, 0);
        check("glitch_frame_err", frame_err, 0);

        // Framing error, then recovery with byte counter back at zero
        send_byte(8'hAA, 1'b0);
        check("frm_err_set", frame_err, 1);
        check("frm_count", fifo_count, 0);
        repeat (20) @(negedge clk);
        send_word(32'h0403_0201, 1'b1);
        check("frm_recover_count", fifo_count, 1);
        pop_check("frm_recover_pop");
        clear_errors();
        check("frm_err_cleared", frame_err, 0);

        // Overrun: fifth word dropped, first four preserved in order
        for (int k = 0; k < 5; k++) send_word(32'hA0B0_C0D0 + 32'(k), k < DEPTH);
        check("ovr_count", fifo_count, 4);
        check("ovr_err", overrun_err, 1);
        check("ovr_frame_err", frame_err, 0);
        for (int k = 0; k < DEPTH; k++) pop_check("ovr_pop");
        check("ovr_drained_valid", rdata_valid, 0);
        clear_errors();
        check("ovr_cleared", overrun_err, 0);

        // Fill, measuring the push latency of the last byte of the fourth word
        for (int k = 0; k < 3; k++) send_word(32'h5000_0000 + 32'(k), 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i), 1'b1);
        t0 = cyc;
        fork
            send_byte(8'h43, 1'b1);
            begin
                for (int n = 0; n < 200; n++) begin
                    @(negedge clk);
                    if (fifo_count == 3'd4) begin
                        lat = cyc - t0;
                        break;
                    end
                end
            end
        join
        sb.push_back(32'h4342_4140);
        check("fill_latency_found", (lat > 1), 1);
        check("fill_count", fifo_count, 4);

        // Fifth word lands exactly while the consumer pops: both succeed
        w5 = 32'hCAFE_F00D;
        lat_use = (lat > 1) ? lat : 80;
        for (int i = 0; i < 3; i++) send_byte(w5[8*i +: 8], 1'b1);
        t0 = cyc;
        fork
            send_byte(w5[31:24], 1'b1);
            begin
                repeat (lat_use - 1) @(negedge clk);
                head = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
                check("simul_head", rdata, head);
                rdata_ready = 1'b1;
                @(negedge clk);
                rdata_ready = 1'b0;
            end
        join
        sb.push_back(w5);
        check("simul_count", fifo_count, 4);
        check("simul_no_overrun", overrun_err, 0);
        for (int k = 0; k < DEPTH; k++) pop_check("simul_drain");
        check("simul_drained_valid", rdata_valid, 0);

`ifdef UART_RX_PARITY_EN
        send_bad_parity(8'h07);
        check("par_err_set", parity_err, 1);
        check("par_dropped_count", fifo_count, 0);
        send_word(32'h0102_0307, 1'b1);
        check("par_ok_count", fifo_count, 1);
        pop_check("par_ok_pop");
        clear_errors();
        check("par_err_cleared", parity_err, 0);
`else
        check("par_tied_low", parity_err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
